// File: rtl/hex_counter_4d.sv
// Four-digit hex up/down counter feeding the 7-segment display mux.
// Edge-detected push-button stepping with hold-to-auto-repeat.
module hex_counter_4d #(
  parameter int CLK_FREQ_HZ     = 12000000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       clear,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] dp_out,
  output logic       wrap_pulse
);

  localparam int DIV =
    (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MSMAX =
    (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
    REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int MW = (MSMAX > 1) ? $clog2(MSMAX + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [MW-1:0] DELAY_C  = MW'(REPEAT_DELAY_MS);
  localparam logic [MW-1:0] RATE_C   = MW'(REPEAT_RATE_MS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_REPEAT,
    S_BLOCKED
  } state_t;

  logic [PW-1:0] r_pre;
  logic [MW-1:0] r_ms;
  logic [15:0]   r_count;
  state_t        r_state;
  logic          r_prev;
  logic          r_dir;
  logic          r_dp0;
  logic          r_dp3;
  logic          r_wrap;

  logic          w_tick;
  logic          w_up;
  logic          w_dn;
  logic          w_both;
  logic          w_press;
  logic          w_rise;
  logic          w_exit;
  logic [MW-1:0] w_ms_inc;
  logic [MW-1:0] w_ms_lim;
  logic [MW-1:0] w_ms_nxt;
  state_t        w_state_nxt;
  logic          w_step;
  logic          w_step_dn;
  logic [15:0]   w_count_nxt;
  logic          w_wrap_hit;

  assign w_tick   = (r_pre == PRE_LAST);
  assign w_up     = btn_up & ~btn_down;
  assign w_dn     = btn_down & ~btn_up;
  assign w_both   = btn_up & btn_down;
  assign w_press  = w_up | w_dn;
  assign w_rise   = w_press & ~r_prev;
  assign w_exit   = ~w_press | (w_dn != r_dir);
  assign w_ms_inc = r_ms + 1'b1;
  assign w_ms_lim = (r_state == S_HELD) ? DELAY_C : RATE_C;

  always_ff @(posedge clk) begin
    if (reset || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Sampling the press level even during reset means a button
  // held through reset needs a fresh press afterwards.
  always_ff @(posedge clk) begin
    r_prev <= w_press;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ms_nxt    = r_ms;
    w_step      = 1'b0;
    w_step_dn   = r_dir;
    case (r_state)
      S_IDLE: begin
        if (w_both) begin
          w_state_nxt = S_BLOCKED;
        end else if (w_rise && !clear) begin
          w_step      = 1'b1;
          w_step_dn   = w_dn;
          w_ms_nxt    = '0;
          w_state_nxt = S_HELD;
        end
      end
      S_HELD, S_REPEAT: begin
        if (w_both) begin
          w_state_nxt = S_BLOCKED;
        end else if (w_exit) begin
          w_state_nxt = S_IDLE;
        end else if (clear) begin
          w_ms_nxt = '0;
        end else if (w_tick) begin
          if (w_ms_inc == w_ms_lim) begin
            w_step      = 1'b1;
            w_ms_nxt    = '0;
            w_state_nxt = S_REPEAT;
          end else begin
            w_ms_nxt = w_ms_inc;
          end
        end
      end
      S_BLOCKED: begin
        if (!btn_up && !btn_down) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_count_nxt = r_count + 16'h0001;
    w_wrap_hit  = (r_count == 16'hFFFF);
    if (w_step_dn) begin
      w_count_nxt = r_count - 16'h0001;
      w_wrap_hit  = (r_count == 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ms    <= '0;
      r_count <= 16'h0000;
      r_dir   <= 1'b0;
      r_dp0   <= 1'b0;
      r_dp3   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ms    <= w_ms_nxt;
      r_wrap  <= 1'b0;
      if (clear) begin
        r_count <= 16'h0000;
        r_dp3   <= 1'b0;
      end else if (w_step) begin
        r_count <= w_count_nxt;
        r_dir   <= w_step_dn;
        r_dp0   <= w_step_dn;
        r_wrap  <= w_wrap_hit;
        r_dp3   <= r_dp3 | w_wrap_hit;
      end
    end
  end

  assign hex0       = r_count[3:0];
  assign hex1       = r_count[7:4];
  assign hex2       = r_count[11:8];
  assign hex3       = r_count[15:12];
  assign dp_out     = {r_dp3, 2'b00, r_dp0};
  assign wrap_pulse = r_wrap;

endmodule
